halt_controller: RTL and testbench
==================================

Name: halt_controller

Overview:
- Run-control stage directly upstream of the phase-clock generator.
- Drives that generator's halt input. Takes back its cycle_clock strobe to count instruction cycles.
- Supports free-run, stop, N-cycle single-stepping and a PC breakpoint.
- Sits between the debug/command interface and the clock generator; all control is in the clk domain.

Parameters:
- ADDR_W, 8: width of pc and bp_addr.
- STEP_W, 8: width of step_count and steps_left.
- CNT_W, 16: width of cycles_retired.

Ports:
- clk  in  1  system clock; everything is on posedge.
- rst_n  in  1  synchronous active-low reset.
- cmd_run  in  1  one-cycle pulse: start free-running.
- cmd_stop  in  1  one-cycle pulse: halt immediately.
- cmd_step  in  1  one-cycle pulse: run step_count instruction cycles, then halt.
- step_count  in  STEP_W  number of cycles to step; sampled on an accepted cmd_step.
- clr_cnt  in  1  clears cycles_retired.
- bp_enable  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint address.
- pc  in  ADDR_W  current program counter from the datapath.
- cycle_clock  in  1  cycle strobe fed back from the clock generator.
- halt  out  1  registered; 1 freezes the clock generator.
- state  out  2  0 = HALTED, 1 = RUNNING, 2 = STEPPING.
- steps_left  out  STEP_W  remaining step cycles.
- cycles_retired  out  CNT_W  count of cycle_clock rising edges seen while not halted.
- bp_hit  out  1  sticky; set when a breakpoint caused the halt.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. rst_n low at a posedge forces the reset values below; it wins over every command, including mid-step.
- Reset values:
  - state = HALTED, halt = 1.
  - steps_left = 0, cycles_retired = 0, bp_hit = 0.
  - cyc_q = 0, skip_bp = 0.
- Edge detect:
  - cyc_q <= cycle_clock.
  - cyc_edge = cycle_clock & ~cyc_q.
  - A strobe held high while frozen counts only once.
- halt is registered and updates on the same edge as state. halt = 1 exactly when the next state is HALTED.
- Command priority when several pulse together: cmd_stop > cmd_step > cmd_run.
- HALTED:
  - cmd_step with step_count != 0: go to STEPPING; steps_left <= step_count; bp_hit <= 0; skip_bp <= 1.
  - cmd_step with step_count == 0: ignored; stay HALTED, nothing changes.
  - cmd_run: go to RUNNING; bp_hit <= 0; skip_bp <= 1.
  - cmd_stop: no effect.
  - cyc_edge is not counted.
- RUNNING:
  - cmd_stop: go to HALTED.
  - Else, on cyc_edge:
    - Breakpoint: if bp_enable && pc == bp_addr && !skip_bp, go to HALTED and set bp_hit <= 1.
    - skip_bp clears on every cyc_edge.
  - cmd_run and cmd_step are ignored.
- STEPPING:
  - cmd_stop: go to HALTED; steps_left <= 0.
  - Else, on cyc_edge:
    - steps_left decrements.
    - If steps_left == 1, go to HALTED with steps_left = 0.
    - The breakpoint rule is the same as RUNNING. On a breakpoint, steps_left <= 0. Breakpoint and last step together: HALTED with bp_hit = 1.
  - cmd_run and cmd_step are ignored.
- skip_bp: ensures resuming while pc == bp_addr does not re-trigger on the first counted cycle.
- cycles_retired:
  - +1 on every cyc_edge while state != HALTED, including the edge that causes a halt.
  - Wraps modulo 2^CNT_W.
  - clr_cnt takes effect next edge and wins over a simultaneous increment (result 0).
- Latency:
  - A command pulse at edge k changes state and halt at edge k.
  - The clock generator sees halt = 0 from edge k + 1.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with cycle_clock toggling -> halt = 1, state = 0, cycles_retired = 0, bp_hit = 0.
- Run/stop: cmd_run, then 5 cycle_clock pulses, then cmd_stop -> state 1 then 0; cycles_retired = 5; halt low only between the two commands.
- Step: cmd_step with step_count = 3, then cycle pulses -> steps_left 3, 2, 1, 0; halt = 1 on the edge of the 3rd pulse; cycles_retired = 3. step_count = 0 -> no state change.
- Breakpoint:
  - bp_enable = 1, bp_addr = 0x10, cmd_run, pc reaches 0x10 on a cycle pulse -> HALTED, bp_hit = 1.
  - cmd_run again with pc still 0x10 -> no re-halt on first pulse; bp_hit = 0.
- Simultaneous commands:
  - cmd_run + cmd_stop in HALTED -> stays HALTED.
  - cmd_step + cmd_run -> STEPPING.
  - clr_cnt coinciding with cyc_edge -> cycles_retired = 0.
- Reset mid-step and wrap:
  - rst_n low during STEPPING with steps_left = 5 -> HALTED, steps_left = 0.
  - CNT_W = 4, 17 pulses while running -> cycles_retired = 1.

Source files
------------

// File: rtl/halt_controller.sv
// Run-control stage for the phase-clock generator: free-run, stop, N-cycle stepping
// and a PC breakpoint, counting retired instruction cycles from the cycle_clock strobe.
module halt_controller #(
    parameter int ADDR_W = 8,
    parameter int STEP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_run,
    input  logic              cmd_stop,
    input  logic              cmd_step,
    input  logic [STEP_W-1:0] step_count,
    input  logic              clr_cnt,
    input  logic              bp_enable,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              cycle_clock,
    output logic              halt,
    output logic [1:0]        state,
    output logic [STEP_W-1:0] steps_left,
    output logic [CNT_W-1:0]  cycles_retired,
    output logic              bp_hit
);

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } state_t;

    state_t st_q;
    logic   cyc_q;
    logic   skip_bp;
    logic   cyc_edge;
    logic   bp_match;

    assign cyc_edge = cycle_clock & ~cyc_q;
    // skip_bp masks the breakpoint for the first counted cycle after a resume
    assign bp_match = bp_enable && (pc == bp_addr) && !skip_bp;
    assign state    = st_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q           <= HALTED;
            halt           <= 1'b1;
            steps_left     <= '0;
            cycles_retired <= '0;
            bp_hit         <= 1'b0;
            cyc_q          <= 1'b0;
            skip_bp        <= 1'b0;
        end else begin
            cyc_q <= cycle_clock;

            if (clr_cnt)
                cycles_retired <= '0;
            else if (cyc_edge && st_q != HALTED)
                cycles_retired <= cycles_retired + CNT_W'(1);

            case (st_q)
                HALTED: begin
                    if (cmd_stop) begin
                        // stop has priority and has nothing to do here
                    end else if (cmd_step && step_count != '0) begin
                        st_q       <= STEPPING;
                        halt       <= 1'b0;
                        steps_left <= step_count;
                        bp_hit     <= 1'b0;
                        skip_bp    <= 1'b1;
                    end else if (cmd_run && !cmd_step) begin
                        st_q    <= RUNNING;
                        halt    <= 1'b0;
                        bp_hit  <= 1'b0;
                        skip_bp <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (cmd_stop) begin
                        st_q <= HALTED;
                        halt <= 1'b1;
                    end else if (cyc_edge) begin
                        skip_bp <= 1'b0;
                        if (bp_match) begin
                            st_q   <= HALTED;
                            halt   <= 1'b1;
                            bp_hit <= 1'b1;
                        end
                    end
                end
                STEPPING: begin
                    if (cmd_stop) begin
                        st_q       <= HALTED;
                        halt       <= 1'b1;
                        steps_left <= '0;
                    end else if (cyc_edge) begin
                        skip_bp <= 1'b0;
                        if (bp_match) begin
                            st_q       <= HALTED;
                            halt       <= 1'b1;
                            steps_left <= '0;
                            bp_hit     <= 1'b1;
                        end else if (steps_left == STEP_W'(1)) begin
                            st_q       <= HALTED;
                            halt       <= 1'b1;
                            steps_left <= '0;
                        end else begin
                            steps_left <= steps_left - STEP_W'(1);
                        end
                    end
                end
                default: begin
                    st_q <= HALTED;
                    halt <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halt_controller.sv
// Directed and randomized checks of halt_controller against a behavioural run-control model.
module tb_halt_controller;

    logic       clk = 1'b0;
    logic       rst_n, cmd_run, cmd_stop, cmd_step, clr_cnt, bp_enable, cycle_clock;
    logic [7:0] step_count, bp_addr, pc;
    logic       halt, bp_hit, halt4, bp_hit4;
    logic [1:0] state, state4;
    logic [7:0] steps_left, steps_left4;
    logic [15:0] cycles_retired;
    logic [3:0]  cycles_retired4;

    int errors = 0;
    int checks = 0;

    // model: mode 0 halted, 1 running, 2 stepping
    int          m_mode, m_steps, m_bphit, m_skip, m_prev;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    halt_controller #(.ADDR_W(8), .STEP_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .step_count(step_count), .clr_cnt(clr_cnt),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc), .cycle_clock(cycle_clock),
        .halt(halt), .state(state), .steps_left(steps_left),
        .cycles_retired(cycles_retired), .bp_hit(bp_hit)
    );

    halt_controller #(.ADDR_W(8), .STEP_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .step_count(step_count), .clr_cnt(clr_cnt),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc), .cycle_clock(cycle_clock),
        .halt(halt4), .state(state4), .steps_left(steps_left4),
        .cycles_retired(cycles_retired4), .bp_hit(bp_hit4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit edge_seen, hit;
        edge_seen = cycle_clock && (m_prev == 0);
        m_prev = cycle_clock ? 1 : 0;
        if (!rst_n) begin
            m_mode = 0; m_steps = 0; m_cnt = 0; m_bphit = 0; m_skip = 0; m_prev = 0;
            return;
        end
        if (clr_cnt) m_cnt = 0;
        else if (edge_seen && m_mode != 0) m_cnt = m_cnt + 1;
        hit = bp_enable && (pc == bp_addr) && (m_skip == 0);
        if (m_mode == 0) begin
            if (!cmd_stop && cmd_step && step_count != 0) begin
                m_mode = 2; m_steps = step_count; m_bphit = 0; m_skip = 1;
            end else if (!cmd_stop && !cmd_step && cmd_run) begin
                m_mode = 1; m_bphit = 0; m_skip = 1;
            end
        end else if (cmd_stop) begin
            m_mode = 0; m_steps = 0;
        end else if (edge_seen) begin
            m_skip = 0;
            if (m_mode == 2) m_steps = m_steps - 1;
            if (hit) begin
                m_mode = 0; m_steps = 0; m_bphit = 1;
            end else if (m_mode == 2 && m_steps == 0) begin
                m_mode = 0;
            end
        end
    endtask

    // advance one clock, then compare both instances with the model
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("halt", 32'(halt), 32'(m_mode == 0));
        chk("state", 32'(state), 32'(m_mode));
        chk("steps_left", 32'(steps_left), 32'(m_steps));
        chk("cycles_retired", 32'(cycles_retired), m_cnt % 65536);
        chk("bp_hit", 32'(bp_hit), 32'(m_bphit));
        chk("state_w4", 32'(state4), 32'(m_mode));
        chk("cycles_retired_w4", 32'(cycles_retired4), m_cnt % 16);
        cmd_run = 0; cmd_stop = 0; cmd_step = 0; clr_cnt = 0;
    endtask

    task automatic pulse();
        cycle_clock = 1; tick();
        cycle_clock = 0; tick();
    endtask

    initial begin
        rst_n = 0; cmd_run = 0; cmd_stop = 0; cmd_step = 0; clr_cnt = 0;
        bp_enable = 0; bp_addr = 8'h10; pc = 8'h00; cycle_clock = 0; step_count = 0;
        m_mode = 0; m_steps = 0; m_cnt = 0; m_bphit = 0; m_skip = 0; m_prev = 0;

        // reset with strobe toggling
        cycle_clock = 1; tick(); cycle_clock = 0; tick(); cycle_clock = 1; tick();
        chk("rst_halt", 32'(halt), 32'd1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", 32'(cycles_retired), 32'd0);
        chk("rst_bp", 32'(bp_hit), 32'd0);
        cycle_clock = 0; rst_n = 1; tick();

        // run / stop
        cmd_run = 1; tick();
        chk("run_state", 32'(state), 32'd1);
        chk("run_halt", 32'(halt), 32'd0);
        repeat (5) pulse();
        chk("run_halt_mid", 32'(halt), 32'd0);
        cmd_stop = 1; tick();
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_halt", 32'(halt), 32'd1);
        chk("run5_cnt", 32'(cycles_retired), 32'd5);

        // step 3
        clr_cnt = 1; tick();
        step_count = 3; cmd_step = 1; tick();
        chk("step_init", 32'(steps_left), 32'd3);
        chk("step_state", 32'(state), 32'd2);
        cycle_clock = 1; tick(); chk("step_2", 32'(steps_left), 32'd2);
        cycle_clock = 0; tick();
        cycle_clock = 1; tick(); chk("step_1", 32'(steps_left), 32'd1);
        chk("step_halt_lo", 32'(halt), 32'd0);
        cycle_clock = 0; tick();
        cycle_clock = 1; tick(); chk("step_0", 32'(steps_left), 32'd0);
        chk("step_done_halt", 32'(halt), 32'd1);
        chk("step_done_state", 32'(state), 32'd0);
        chk("step_cnt", 32'(cycles_retired), 32'd3);
        cycle_clock = 0; tick();
        step_count = 0; cmd_step = 1; tick();
        chk("step_zero", 32'(state), 32'd0);

        // breakpoint
        bp_enable = 1; bp_addr = 8'h10; pc = 8'h0E;
        cmd_run = 1; tick();
        pc = 8'h0F; pulse();
        chk("bp_pre", 32'(state), 32'd1);
        pc = 8'h10; cycle_clock = 1; tick();
        chk("bp_state", 32'(state), 32'd0);
        chk("bp_hit", 32'(bp_hit), 32'd1);
        cycle_clock = 0; tick();
        cmd_run = 1; tick();
        chk("bp_resume_clr", 32'(bp_hit), 32'd0);
        pulse();
        chk("bp_skip", 32'(state), 32'd1);
        pulse();
        chk("bp_rehit", 32'(state), 32'd0);
        chk("bp_rehit_flag", 32'(bp_hit), 32'd1);

        // simultaneous commands
        bp_enable = 0;
        cmd_run = 1; cmd_stop = 1; tick();
        chk("run_stop_halted", 32'(state), 32'd0);
        step_count = 2; cmd_step = 1; cmd_run = 1; tick();
        chk("step_over_run", 32'(state), 32'd2);
        cycle_clock = 1; clr_cnt = 1; tick();
        chk("clr_wins", 32'(cycles_retired), 32'd0);
        cycle_clock = 0; cmd_stop = 1; tick();

        // reset mid-step
        step_count = 5; cmd_step = 1; tick();
        chk("mid_step5", 32'(steps_left), 32'd5);
        rst_n = 0; tick();
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_steps", 32'(steps_left), 32'd0);
        rst_n = 1; tick();

        // counter wrap on the CNT_W=4 instance
        cmd_run = 1; tick();
        repeat (17) pulse();
        chk("wrap_w4", 32'(cycles_retired4), 32'd1);
        chk("wrap_w16", 32'(cycles_retired), 32'd17);
        cmd_stop = 1; tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cmd_run     = ($urandom_range(0, 11) == 0);
            cmd_stop    = ($urandom_range(0, 29) == 0);
            cmd_step    = ($urandom_range(0, 11) == 0);
            step_count  = 8'($urandom_range(0, 6));
            if (cmd_step && step_count == 0) cmd_run = 0;
            clr_cnt     = ($urandom_range(0, 63) == 0);
            rst_n       = ($urandom_range(0, 249) != 0);
            cycle_clock = ($urandom_range(0, 1) == 1);
            pc          = 8'($urandom_range(8'h0E, 8'h12));
            bp_enable   = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
